// File: rtl/dual_issue_dispatch_ctrl.sv
// Dual-lane dispatch scheduler: scoreboard-steered lane choice with credit tracking.
// Optional per-lane / per-stall-cause counters are built when DISPATCH_STATS_EN is defined.
module dual_issue_dispatch_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   output logic        fifo1_wr_en,
   output logic        fifo2_wr_en,
   output logic [31:0] instr_out,
   input  logic        fifo1_pop,
   input  logic        fifo2_pop,
   input  logic        ret1_valid,
   input  logic [4:0]  ret1_dest,
   input  logic        ret2_valid,
   input  logic [4:0]  ret2_dest,
   output logic        busy
`ifdef DISPATCH_STATS_EN
   ,
   output logic [15:0] stat_disp1,
   output logic [15:0] stat_disp2,
   output logic [15:0] stat_stall_haz,
   output logic [15:0] stat_stall_full
`endif
);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e           state_q, state_d;
   logic [31:0]      hold_q, hold_d;
   logic [31:0]      instr_q, instr_d;
   logic             wr1_q, wr1_d;
   logic             wr2_q, wr2_d;
   logic             rr_q, rr_d;
   logic [CNT_W-1:0] cred1_q, cred1_d;
   logic [CNT_W-1:0] cred2_q, cred2_d;
   logic [CNT_W-1:0] pend_q [32];
   logic [CNT_W-1:0] pend_d [32];
   logic [31:0]      own_q, own_d;

   logic [31:0] cand;
   logic        cand_v;
   logic [4:0]  s1, s2, dst;
   logic [1:0]  route;
   logic        o1, o2, od;
   logic        need1, need2;
   logic        full1, full2;
   logic        ok1, ok2, av1, av2;
   logic        go, tie, lane, haz;
   logic        inc1, dec1, inc2, dec2;

   always_comb begin
      cand   = (state_q == HOLD) ? hold_q : in_instr;
      cand_v = (state_q == HOLD) || in_valid;
      s1     = cand[20:16];
      s2     = cand[15:11];
      dst    = cand[4:0];
      route  = cand[28:27];
      o1     = (s1 != 5'd0) && (pend_q[s1] != '0);
      o2     = (s2 != 5'd0) && (pend_q[s2] != '0);
      od     = (dst != 5'd0) && (pend_q[dst] != '0);
      need1  = (o1 && !own_q[s1]) || (o2 && !own_q[s2]) || (od && !own_q[dst]);
      need2  = (o1 && own_q[s1]) || (o2 && own_q[s2]) || (od && own_q[dst]);
      full1  = cred1_q == CNT_W'(FIFO_DEPTH);
      full2  = cred2_q == CNT_W'(FIFO_DEPTH);
      // a lane is legal if nothing pins the instruction to the other lane
      ok1    = !need2 && !(route == 2'b11);
      ok2    = !need1 && !(route == 2'b10);
      haz    = !ok1 && !ok2;
      av1    = ok1 && !full1;
      av2    = ok2 && !full2;
      go     = cand_v && (av1 || av2);
      tie    = av1 && av2 && (cred1_q == cred2_q);
      if (av1 && av2)
         lane = tie ? rr_q : (cred2_q < cred1_q);
      else
         lane = av2;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (go) begin
         state_d = IDLE;
      end else if (cand_v) begin
         state_d = HOLD;
         hold_d  = cand;
      end
      wr1_d   = go && !lane;
      wr2_d   = go && lane;
      instr_d = go ? cand : instr_q;
      rr_d    = rr_q ^ (go && tie);
      inc1    = wr1_d;
      inc2    = wr2_d;
      dec1    = fifo1_pop && (cred1_q != '0);
      dec2    = fifo2_pop && (cred2_q != '0);
      cred1_d = cred1_q + CNT_W'(inc1) - CNT_W'(dec1);
      cred2_d = cred2_q + CNT_W'(inc2) - CNT_W'(dec2);
      pend_d[0] = '0;
      own_d     = own_q;
      own_d[0]  = 1'b0;
      for (int r = 1; r < 32; r++) begin
         pend_d[r] = pend_q[r]
            + CNT_W'(go && (dst == 5'(r)))
            - CNT_W'((pend_q[r] != '0) &&
                     ((ret1_valid && (ret1_dest == 5'(r)) && !own_q[r]) ||
                      (ret2_valid && (ret2_dest == 5'(r)) && own_q[r])));
         if (go && (dst == 5'(r)))
            own_d[r] = lane;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         instr_q <= '0;
         wr1_q   <= 1'b0;
         wr2_q   <= 1'b0;
         rr_q    <= 1'b0;
         cred1_q <= '0;
         cred2_q <= '0;
         pend_q  <= '{default: '0};
         own_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         wr1_q   <= wr1_d;
         wr2_q   <= wr2_d;
         rr_q    <= rr_d;
         cred1_q <= cred1_d;
         cred2_q <= cred2_d;
         pend_q  <= pend_d;
         own_q   <= own_d;
      end
   end

   assign in_ready    = !rst && (state_q == IDLE);
   assign busy        = (state_q == HOLD);
   assign fifo1_wr_en = wr1_q;
   assign fifo2_wr_en = wr2_q;
   assign instr_out   = instr_q;

`ifdef DISPATCH_STATS_EN
   logic [15:0] sd1_q, sd1_d, sd2_q, sd2_d;
   logic [15:0] sh_q, sh_d, sf_q, sf_d;

   always_comb begin
      sd1_d = sd1_q + 16'(wr1_d && (sd1_q != '1));
      sd2_d = sd2_q + 16'(wr2_d && (sd2_q != '1));
      sh_d  = sh_q + 16'((state_q == HOLD) && haz && (sh_q != '1));
      sf_d  = sf_q + 16'((state_q == HOLD) && !go && !haz && (sf_q != '1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sd1_q <= '0;
         sd2_q <= '0;
         sh_q  <= '0;
         sf_q  <= '0;
      end else begin
         sd1_q <= sd1_d;
         sd2_q <= sd2_d;
         sh_q  <= sh_d;
         sf_q  <= sf_d;
      end
   end

   assign stat_disp1      = sd1_q;
   assign stat_disp2      = sd2_q;
   assign stat_stall_haz  = sh_q;
   assign stat_stall_full = sf_q;
`endif

endmodule

// File: tb/tb_dual_issue_dispatch_ctrl.sv
// Bench for dual_issue_dispatch_ctrl: directed scenarios plus random traffic
// against a lane-mask reference model.
module tb_dual_issue_dispatch_ctrl;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        fifo1_wr_en;
   logic        fifo2_wr_en;
   logic [31:0] instr_out;
   logic        fifo1_pop;
   logic        fifo2_pop;
   logic        ret1_valid;
   logic [4:0]  ret1_dest;
   logic        ret2_valid;
   logic [4:0]  ret2_dest;
   logic        busy;
`ifdef DISPATCH_STATS_EN
   logic [15:0] stat_disp1, stat_disp2, stat_stall_haz, stat_stall_full;
`endif

   int n_chk = 0;
   int n_fail = 0;

   int          m_pend [32];
   int          m_own  [32];
   int          m_cred [2];
   int          m_rr;
   bit          m_hv;
   logic [31:0] m_hold;
   logic        e_wr1, e_wr2, e_busy;
   logic [31:0] e_instr;

   dual_issue_dispatch_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .fifo1_wr_en(fifo1_wr_en),
      .fifo2_wr_en(fifo2_wr_en), .instr_out(instr_out),
      .fifo1_pop(fifo1_pop), .fifo2_pop(fifo2_pop),
      .ret1_valid(ret1_valid), .ret1_dest(ret1_dest),
      .ret2_valid(ret2_valid), .ret2_dest(ret2_dest),
      .busy(busy)
`ifdef DISPATCH_STATS_EN
      , .stat_disp1(stat_disp1), .stat_disp2(stat_disp2),
      .stat_stall_haz(stat_stall_haz), .stat_stall_full(stat_stall_full)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_pend[r] = 0;
         m_own[r]  = 0;
      end
      m_cred[0] = 0;
      m_cred[1] = 0;
      m_rr    = 0;
      m_hv    = 0;
      m_hold  = '0;
      e_wr1   = 0;
      e_wr2   = 0;
      e_busy  = 0;
      e_instr = '0;
   endtask

   // Returns 0/1 for lane 1/2, or -1 when the instruction must wait.
   function automatic int pick(input logic [31:0] ins, output bit tie);
      int req, allow;
      int regs [3];
      tie = 0;
      req = 0;
      regs[0] = int'(ins[20:16]);
      regs[1] = int'(ins[15:11]);
      regs[2] = int'(ins[4:0]);
      foreach (regs[k])
         if (regs[k] != 0 && m_pend[regs[k]] > 0)
            req |= (1 << m_own[regs[k]]);
      if (req == 3) return -1;
      allow = 3;
      if (ins[28:27] == 2'b10) allow = 1;
      if (ins[28:27] == 2'b11) allow = 2;
      if (req != 0) begin
         if ((allow & req) == 0) return -1;
         allow = allow & req;
      end
      if (m_cred[0] == DEPTH) allow = allow & 2;
      if (m_cred[1] == DEPTH) allow = allow & 1;
      if (allow == 0) return -1;
      if (allow == 1) return 0;
      if (allow == 2) return 1;
      if (m_cred[0] < m_cred[1]) return 0;
      if (m_cred[1] < m_cred[0]) return 1;
      tie = 1;
      return m_rr;
   endfunction

   // Advance the reference model with the currently driven inputs, then one clock.
   task automatic clk_step();
      bit          tie, have;
      int          lane, d;
      logic [31:0] cand;
      if (rst) begin
         model_reset();
      end else begin
         have = m_hv || in_valid;
         cand = m_hv ? m_hold : in_instr;
         tie  = 0;
         lane = have ? pick(cand, tie) : -1;
         e_wr1 = (lane == 0);
         e_wr2 = (lane == 1);
         if (lane >= 0) e_instr = cand;
         if (have && lane < 0) begin
            m_hv   = 1;
            m_hold = cand;
         end else if (lane >= 0) begin
            m_hv = 0;
         end
         e_busy = m_hv;
         if (lane >= 0 && tie) m_rr = 1 - m_rr;
         if (fifo1_pop && m_cred[0] > 0) m_cred[0]--;
         if (fifo2_pop && m_cred[1] > 0) m_cred[1]--;
         if (lane >= 0) m_cred[lane]++;
         if (ret1_valid && ret1_dest != 0 && m_pend[ret1_dest] > 0 && m_own[ret1_dest] == 0)
            m_pend[ret1_dest]--;
         if (ret2_valid && ret2_dest != 0 && m_pend[ret2_dest] > 0 && m_own[ret2_dest] == 1)
            m_pend[ret2_dest]--;
         d = int'(cand[4:0]);
         if (lane >= 0 && d != 0) begin
            m_pend[d]++;
            m_own[d] = lane;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      in_valid   = 0;
      in_instr   = '0;
      fifo1_pop  = 0;
      fifo2_pop  = 0;
      ret1_valid = 0;
      ret1_dest  = '0;
      ret2_valid = 0;
      ret2_dest  = '0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1;
      clk_step();
      rst = 0;
   endtask

   task automatic send(input logic [31:0] ins);
      in_valid = 1;
      in_instr = ins;
      clk_step();
      in_valid = 0;
   endtask

   task automatic test_reset();
      quiet();
      rst = 1;
      in_valid = 1;
      in_instr = 32'h1000_0001;
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0", in_ready);
      end
      clk_step();
      clk_step();
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b expected 000", {fifo1_wr_en, fifo2_wr_en, busy});
      end
      n_chk++;
      if (instr_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_instr: got %h expected 0", instr_out);
      end
      rst = 0;
      in_valid = 0;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_override_and_dep();
      do_reset();
      send(32'h1000_0001);
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en} !== 2'b10 || instr_out !== 32'h1000_0001) begin
         n_fail++;
         $display("FAIL override_lane1: got wr=%b instr=%h expected wr=10 instr=10000001",
                  {fifo1_wr_en, fifo2_wr_en}, instr_out);
      end
      send(32'h0001_0003);
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en} !== 2'b10 || instr_out !== 32'h0001_0003) begin
         n_fail++;
         $display("FAIL dep_same_lane: got wr=%b instr=%h expected wr=10 instr=00010003",
                  {fifo1_wr_en, fifo2_wr_en}, instr_out);
      end
   endtask

   task automatic test_hazard();
      do_reset();
      send(32'h1000_0001);
      send(32'h1800_0002);
      n_chk++;
      if (fifo2_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL haz_setup_lane2: got %b expected 1", fifo2_wr_en);
      end
      send(32'h0001_1005);
      #1;
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy, in_ready} !== 4'b0010) begin
         n_fail++;
         $display("FAIL haz_hold: got wr1,wr2,busy,rdy=%b expected 0010",
                  {fifo1_wr_en, fifo2_wr_en, busy, in_ready});
      end
      ret2_valid = 1;
      ret2_dest  = 5'd2;
      clk_step();
      ret2_valid = 0;
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy} !== 3'b001) begin
         n_fail++;
         $display("FAIL haz_retire_cycle: got %b expected 001", {fifo1_wr_en, fifo2_wr_en, busy});
      end
      clk_step();
      #1;
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy, in_ready} !== 4'b1001 || instr_out !== 32'h0001_1005) begin
         n_fail++;
         $display("FAIL haz_release: got wr1,wr2,busy,rdy=%b instr=%h expected 1001 instr=00011005",
                  {fifo1_wr_en, fifo2_wr_en, busy, in_ready}, instr_out);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         send(32'h1800_0000);
         n_chk++;
         if (fifo2_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL full_fill_%0d: got %b expected 1", i, fifo2_wr_en);
         end
      end
      send(32'h1800_0000);
      clk_step();
      n_chk++;
      if ({fifo2_wr_en, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL full_stall: got wr2,busy=%b expected 01", {fifo2_wr_en, busy});
      end
      fifo2_pop = 1;
      clk_step();
      fifo2_pop = 0;
      n_chk++;
      if ({fifo2_wr_en, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL full_pop_cycle: got wr2,busy=%b expected 01", {fifo2_wr_en, busy});
      end
      clk_step();
      n_chk++;
      if ({fifo2_wr_en, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL full_release: got wr2,busy=%b expected 10", {fifo2_wr_en, busy});
      end
      send(32'h1800_0000);
      n_chk++;
      if ({fifo2_wr_en, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL full_credit_kept: got wr2,busy=%b expected 01", {fifo2_wr_en, busy});
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(32'h0000_0000);
         n_chk++;
         if (fifo1_wr_en !== (i % 2 == 0) || fifo2_wr_en !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL rr_alt_%0d: got wr=%b%b expected lane%0d",
                     i, fifo1_wr_en, fifo2_wr_en, (i % 2) + 1);
         end
         fifo1_pop = (i % 2 == 0);
         fifo2_pop = (i % 2 == 1);
         clk_step();
         fifo1_pop = 0;
         fifo2_pop = 0;
      end
      for (int i = 0; i < 3; i++) begin
         send(32'h0000_0000);
         n_chk++;
         if (fifo1_wr_en !== e_wr1 || fifo2_wr_en !== e_wr2) begin
            n_fail++;
            $display("FAIL rr_nopop_%0d: got wr=%b%b expected %b%b",
                     i, fifo1_wr_en, fifo2_wr_en, e_wr1, e_wr2);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      send(32'h1000_0001);
      send(32'h1800_0002);
      send(32'h0001_1005);
      rst = 1;
      #1;
      n_chk++;
      if ({busy, in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL rih_pre: got busy,rdy=%b expected 10", {busy, in_ready});
      end
      clk_step();
      rst = 0;
      #1;
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy, in_ready} !== 4'b0001 || instr_out !== 32'h0) begin
         n_fail++;
         $display("FAIL rih_after: got wr1,wr2,busy,rdy=%b instr=%h expected 0001 instr=0",
                  {fifo1_wr_en, fifo2_wr_en, busy, in_ready}, instr_out);
      end
      for (int i = 0; i < 2; i++) begin
         clk_step();
         n_chk++;
         if ({fifo1_wr_en, fifo2_wr_en} !== 2'b00 || instr_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rih_dropped_%0d: got wr=%b%b instr=%h expected 00 instr=0",
                     i, fifo1_wr_en, fifo2_wr_en, instr_out);
         end
      end
      send(32'h0001_1005);
      n_chk++;
      if ({fifo1_wr_en, fifo2_wr_en, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL rih_cleared: got wr1,wr2,busy=%b expected 100",
                  {fifo1_wr_en, fifo2_wr_en, busy});
      end
   endtask

   task automatic test_random();
      logic exp_rdy;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         in_valid   = 1'($urandom_range(0, 1));
         in_instr   = $urandom;
         in_instr[20:16] = 5'($urandom_range(0, 3));
         in_instr[15:11] = 5'($urandom_range(0, 3));
         in_instr[4:0]   = 5'($urandom_range(0, 3));
         fifo1_pop  = ($urandom_range(0, 2) == 0);
         fifo2_pop  = ($urandom_range(0, 2) == 0);
         ret1_valid = ($urandom_range(0, 3) != 0);
         ret1_dest  = 5'($urandom_range(1, 3));
         ret2_valid = ($urandom_range(0, 3) != 0);
         ret2_dest  = 5'($urandom_range(1, 3));
         exp_rdy    = !rst && !m_hv;
         #1;
         n_chk++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rand_ready_%0d: got %b expected %b", i, in_ready, exp_rdy);
         end
         clk_step();
         n_chk++;
         if (fifo1_wr_en !== e_wr1 || fifo2_wr_en !== e_wr2 ||
             busy !== e_busy || instr_out !== e_instr) begin
            n_fail++;
            $display("FAIL rand_out_%0d: got wr=%b%b busy=%b instr=%h expected wr=%b%b busy=%b instr=%h",
                     i, fifo1_wr_en, fifo2_wr_en, busy, instr_out,
                     e_wr1, e_wr2, e_busy, e_instr);
         end
      end
      rst = 0;
      quiet();
   endtask

   initial begin
      quiet();
      rst = 1;
      model_reset();
      test_reset();
      test_override_and_dep();
      test_hazard();
      test_full();
      test_round_robin();
      test_reset_in_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
